// File: rtl/fetch_stage.sv
// Instruction-fetch stage: internal instruction memory, next-PC selection,
// and the IF/ID pipeline register with stall, branch flush and HALT freeze.
module fetch_stage #(
  parameter int PC_WIDTH = 6,
  parameter int INSTR_WIDTH = 32,
  parameter logic [INSTR_WIDTH-1:0] HALT_WORD = '1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PC_WIDTH-1:0]    pc,
  output logic [PC_WIDTH-1:0]    next_pc,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic                   imem_we,
  input  logic [PC_WIDTH-1:0]    imem_waddr,
  input  logic [INSTR_WIDTH-1:0] imem_wdata,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [PC_WIDTH-1:0]    if_id_pc,
  output logic                   if_id_valid,
  output logic                   halted,
  output logic [15:0]            fetch_count
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t state, state_nx;

  logic [INSTR_WIDTH-1:0] mem [2**PC_WIDTH];
  logic [INSTR_WIDTH-1:0] rd_word;
  logic                   rd_halt;
  logic                   capture;

  // Asynchronous read; a same-cycle write to this address lands after the edge,
  // so the capture sees the old word.
  assign rd_word = mem[pc];
  assign rd_halt = (rd_word == HALT_WORD);

  // Stall and branch both block a capture; the halt freeze blocks it too.
  assign capture = !branch_taken && !stall && (state == RUN);

  assign halted = (state == HALTED);

  always_ff @(posedge clk) begin
    if (imem_we) mem[imem_waddr] <= imem_wdata;
  end

  always_comb begin
    next_pc = pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
    if (branch_taken)
      next_pc = branch_target;
    else if (stall)
      next_pc = pc;
    else if ((state == HALTED) || rd_halt)
      next_pc = pc;
  end

  always_comb begin
    state_nx = state;
    case (state)
      RUN:     if (capture && rd_halt) state_nx = HALTED;
      HALTED:  if (branch_taken) state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_instr <= '0;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
    end else if (branch_taken || (!stall && (state == HALTED))) begin
      if_id_instr <= '0;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
    end else if (capture) begin
      if_id_instr <= rd_word;
      if_id_pc    <= pc;
      if_id_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      fetch_count <= '0;
    else if (capture && (fetch_count != 16'hFFFF))
      fetch_count <= fetch_count + 16'd1;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// traffic checked against a behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  pc;
  logic [5:0]  next_pc;
  logic        stall;
  logic        branch_taken;
  logic [5:0]  branch_target;
  logic        imem_we;
  logic [5:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic [31:0] if_id_instr;
  logic [5:0]  if_id_pc;
  logic        if_id_valid;
  logic        halted;
  logic [15:0] fetch_count;

  int n_total = 0;
  int n_pass  = 0;

  // Behavioural model of the fetch rules
  logic [31:0] m_mem [64];
  logic [31:0] m_instr;
  logic [5:0]  m_ipc;
  logic        m_valid;
  logic        m_halted;
  int          m_count;
  logic [31:0] exp_q[$];

  fetch_stage dut (
    .clk(clk), .rst(rst), .pc(pc), .next_pc(next_pc), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid),
    .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] model_next_pc();
    logic [5:0] r;
    if (branch_taken) r = branch_target;
    else if (stall) r = pc;
    else if (m_halted || (m_mem[pc] == HALT)) r = pc;
    else r = 6'((int'(pc) + 1) % 64);
    return r;
  endfunction

  function automatic void model_reset();
    m_instr = '0; m_ipc = '0; m_valid = 1'b0; m_halted = 1'b0; m_count = 0;
  endfunction

  // One rising edge: the model advances on the inputs held across it, and
  // the bench acts as the PC register by loading the modelled next PC.
  task automatic apply_edge();
    logic [5:0] np;
    np = model_next_pc();
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else if (branch_taken) begin
      m_instr = '0; m_ipc = '0; m_valid = 1'b0; m_halted = 1'b0;
    end else if (stall) begin
      // IF/ID holds
    end else if (m_halted) begin
      m_instr = '0; m_ipc = '0; m_valid = 1'b0;
    end else begin
      m_instr = m_mem[pc]; m_ipc = pc; m_valid = 1'b1;
      if (m_count < 65535) m_count++;
      if (m_mem[pc] == HALT) m_halted = 1'b1;
    end
    if (imem_we) m_mem[imem_waddr] = imem_wdata;
    if (!rst) pc = np;
  endtask

  task automatic load_word(input logic [5:0] a, input logic [31:0] d);
    imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
    apply_edge();
    imem_we = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] abcd [4];
    logic [31:0] e;
    abcd[0] = 32'hA000_000A; abcd[1] = 32'hB000_000B;
    abcd[2] = 32'hC000_000C; abcd[3] = 32'hD000_000D;
    rst = 1'b1; model_reset();
    #1;
    n_total++; if (if_id_instr !== 32'd0) $display("FAIL reset_instr: got %0h expected 0", if_id_instr); else n_pass++;
    n_total++; if (if_id_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", if_id_valid); else n_pass++;
    n_total++; if (halted !== 1'b0) $display("FAIL reset_halted: got %0b expected 0", halted); else n_pass++;
    n_total++; if (fetch_count !== 16'd0) $display("FAIL reset_count: got %0d expected 0", fetch_count); else n_pass++;
    for (int a = 0; a < 64; a++)
      load_word(6'(a), (a < 4) ? abcd[a] : ($urandom() & 32'h7FFF_FFFF));
    for (int i = 0; i < 4; i++) exp_q.push_back(abcd[i]);
    pc = 6'd0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      apply_edge();
      e = exp_q.pop_front();
      n_total++; if (if_id_instr !== e) $display("FAIL seq_instr%0d: got %0h expected %0h", i, if_id_instr, e); else n_pass++;
      n_total++; if (if_id_pc !== 6'(i)) $display("FAIL seq_pc%0d: got %0d expected %0d", i, if_id_pc, i); else n_pass++;
      n_total++; if (if_id_valid !== 1'b1) $display("FAIL seq_valid%0d: got %0b expected 1", i, if_id_valid); else n_pass++;
    end
    n_total++; if (fetch_count !== 16'd4) $display("FAIL seq_count: got %0d expected 4", fetch_count); else n_pass++;
  endtask

  task automatic test_wrap();
    pc = 6'd63;
    #1;
    n_total++; if (next_pc !== 6'd0) $display("FAIL wrap_next_pc: got %0d expected 0", next_pc); else n_pass++;
    apply_edge();
    n_total++; if (if_id_pc !== 6'd63) $display("FAIL wrap_if_id_pc: got %0d expected 63", if_id_pc); else n_pass++;
    n_total++; if (if_id_instr !== m_mem[63]) $display("FAIL wrap_instr: got %0h expected %0h", if_id_instr, m_mem[63]); else n_pass++;
  endtask

  task automatic test_stall();
    logic [31:0] held;
    held = m_mem[63];
    pc = 6'd5; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++; if (next_pc !== 6'd5) $display("FAIL stall_next_pc%0d: got %0d expected 5", i, next_pc); else n_pass++;
      apply_edge();
      n_total++; if (if_id_pc !== 6'd63) $display("FAIL stall_hold_pc%0d: got %0d expected 63", i, if_id_pc); else n_pass++;
      n_total++; if (if_id_instr !== held) $display("FAIL stall_hold_instr%0d: got %0h expected %0h", i, if_id_instr, held); else n_pass++;
      n_total++; if (fetch_count !== 16'd5) $display("FAIL stall_count%0d: got %0d expected 5", i, fetch_count); else n_pass++;
    end
    stall = 1'b0;
  endtask

  task automatic test_branch_stall();
    pc = 6'd10; branch_taken = 1'b1; branch_target = 6'd40; stall = 1'b1;
    #1;
    n_total++; if (next_pc !== 6'd40) $display("FAIL br_next_pc: got %0d expected 40", next_pc); else n_pass++;
    apply_edge();
    branch_taken = 1'b0; stall = 1'b0;
    n_total++; if (if_id_valid !== 1'b0) $display("FAIL br_bubble_valid: got %0b expected 0", if_id_valid); else n_pass++;
    n_total++; if (if_id_instr !== 32'd0) $display("FAIL br_bubble_instr: got %0h expected 0", if_id_instr); else n_pass++;
    n_total++; if (fetch_count !== 16'd5) $display("FAIL br_count: got %0d expected 5", fetch_count); else n_pass++;
    #1;
    n_total++; if (next_pc !== 6'd41) $display("FAIL br_target_next_pc: got %0d expected 41", next_pc); else n_pass++;
    apply_edge();
    n_total++; if (if_id_pc !== 6'd40) $display("FAIL br_target_pc: got %0d expected 40", if_id_pc); else n_pass++;
    n_total++; if (if_id_valid !== 1'b1) $display("FAIL br_target_valid: got %0b expected 1", if_id_valid); else n_pass++;
    n_total++; if (if_id_instr !== m_mem[40]) $display("FAIL br_target_instr: got %0h expected %0h", if_id_instr, m_mem[40]); else n_pass++;
  endtask

  task automatic test_same_addr_write();
    logic [31:0] old_w;
    logic [31:0] new_w;
    old_w = m_mem[20];
    new_w = 32'h1234_5678;
    pc = 6'd20;
    imem_we = 1'b1; imem_waddr = 6'd20; imem_wdata = new_w;
    apply_edge();
    imem_we = 1'b0;
    n_total++; if (if_id_instr !== old_w) $display("FAIL rw_old: got %0h expected %0h", if_id_instr, old_w); else n_pass++;
    pc = 6'd20;
    apply_edge();
    n_total++; if (if_id_instr !== new_w) $display("FAIL rw_new: got %0h expected %0h", if_id_instr, new_w); else n_pass++;
  endtask

  task automatic test_halt();
    rst = 1'b1; model_reset();
    load_word(6'd7, HALT);
    rst = 1'b0; pc = 6'd0;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_total++; if (next_pc !== ((i == 7) ? 6'd7 : 6'(i + 1))) $display("FAIL halt_run_next_pc%0d: got %0d", i, next_pc); else n_pass++;
      apply_edge();
      n_total++; if (if_id_pc !== 6'(i)) $display("FAIL halt_run_pc%0d: got %0d expected %0d", i, if_id_pc, i); else n_pass++;
      n_total++; if (halted !== (i == 7)) $display("FAIL halt_flag%0d: got %0b expected %0b", i, halted, i == 7); else n_pass++;
    end
    n_total++; if (if_id_instr !== HALT) $display("FAIL halt_captured: got %0h expected %0h", if_id_instr, HALT); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++; if (next_pc !== 6'd7) $display("FAIL halt_park%0d: got %0d expected 7", i, next_pc); else n_pass++;
      apply_edge();
      n_total++; if (if_id_valid !== 1'b0) $display("FAIL halt_bubble%0d: got %0b expected 0", i, if_id_valid); else n_pass++;
      n_total++; if (halted !== 1'b1) $display("FAIL halt_stay%0d: got %0b expected 1", i, halted); else n_pass++;
    end
    n_total++; if (fetch_count !== 16'd8) $display("FAIL halt_count: got %0d expected 8", fetch_count); else n_pass++;
    branch_taken = 1'b1; branch_target = 6'd2;
    #1;
    n_total++; if (next_pc !== 6'd2) $display("FAIL halt_br_next_pc: got %0d expected 2", next_pc); else n_pass++;
    apply_edge();
    branch_taken = 1'b0;
    n_total++; if (halted !== 1'b0) $display("FAIL halt_release: got %0b expected 0", halted); else n_pass++;
    apply_edge();
    n_total++; if (if_id_pc !== 6'd2) $display("FAIL halt_resume_pc: got %0d expected 2", if_id_pc); else n_pass++;
    n_total++; if (if_id_valid !== 1'b1) $display("FAIL halt_resume_valid: got %0b expected 1", if_id_valid); else n_pass++;
    load_word(6'd7, 32'h0000_0777);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) apply_edge();
    #2;
    rst = 1'b1;
    #1;
    n_total++; if (if_id_instr !== 32'd0) $display("FAIL arst_instr: got %0h expected 0", if_id_instr); else n_pass++;
    n_total++; if (if_id_pc !== 6'd0) $display("FAIL arst_pc: got %0d expected 0", if_id_pc); else n_pass++;
    n_total++; if (if_id_valid !== 1'b0) $display("FAIL arst_valid: got %0b expected 0", if_id_valid); else n_pass++;
    n_total++; if (fetch_count !== 16'd0) $display("FAIL arst_count: got %0d expected 0", fetch_count); else n_pass++;
    model_reset();
    apply_edge();
    rst = 1'b0; pc = 6'd0;
  endtask

  task automatic test_random();
    logic [5:0] e_np;
    for (int i = 0; i < 300; i++) begin
      stall         = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 9) == 0);
      branch_target = 6'($urandom_range(0, 63));
      imem_we       = ($urandom_range(0, 2) == 0);
      imem_waddr    = 6'($urandom_range(0, 63));
      imem_wdata    = ($urandom_range(0, 5) == 0) ? HALT : $urandom();
      #1;
      e_np = model_next_pc();
      n_total++; if (next_pc !== e_np) $display("FAIL rnd_next_pc%0d: got %0d expected %0d", i, next_pc, e_np); else n_pass++;
      apply_edge();
      n_total++; if (if_id_instr !== m_instr) $display("FAIL rnd_instr%0d: got %0h expected %0h", i, if_id_instr, m_instr); else n_pass++;
      n_total++; if (if_id_pc !== m_ipc) $display("FAIL rnd_pc%0d: got %0d expected %0d", i, if_id_pc, m_ipc); else n_pass++;
      n_total++; if (if_id_valid !== m_valid) $display("FAIL rnd_valid%0d: got %0b expected %0b", i, if_id_valid, m_valid); else n_pass++;
      n_total++; if (halted !== m_halted) $display("FAIL rnd_halted%0d: got %0b expected %0b", i, halted, m_halted); else n_pass++;
      n_total++; if (fetch_count !== 16'(m_count)) $display("FAIL rnd_count%0d: got %0d expected %0d", i, fetch_count, m_count); else n_pass++;
    end
    stall = 1'b0; branch_taken = 1'b0; imem_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pc = '0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    test_reset();
    test_wrap();
    test_stall();
    test_branch_stall();
    test_same_addr_write();
    test_halt();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
